router_output_arbiter: RTL and testbench
========================================

ROUTER_OUTPUT_ARBITER -- requirements
Module: router_output_arbiter

Interface
REQ-001 Parameter NUM_IN, default 5, number of input buffers competing for this output port (4 mesh directions + local).
REQ-002 Parameter PORT_ID, default 3'd0, target code served by this output port.
REQ-003 Parameter TIMEOUT, default 64, stall cycles before a flit is dropped (used only with ARB_TIMEOUT_EN).
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 head  input  NUM_IN*23  flattened buffer heads; slice i = head[23*i+22:23*i]; bits 22:7 payload, 6:3 address, 2:0 target.
REQ-007 head_valid  input  NUM_IN  bit i = 1 when input buffer i holds at least one flit.
REQ-008 pop  output  NUM_IN  per-buffer pop request, at most one bit high per cycle.
REQ-009 out_data  output  23  registered flit presented to the output link.
REQ-010 out_valid  output  1  out_data holds a flit.
REQ-011 out_ready  input  1  downstream accepts out_data on a cycle where out_valid=1 and out_ready=1.
REQ-012 grant_id  output  3  index of the input that supplied out_data.
REQ-013 drop  output  1  one-cycle pulse when a stalled flit is discarded.

Function
REQ-014 Request req[i] SHALL be head_valid[i] AND head slice i bits 2:0 == PORT_ID.
REQ-015 States SHALL be IDLE (out_valid=0) and SEND (out_valid=1); no other states.
REQ-016 Arbitration SHALL be round-robin: winner g = first i with req[i]=1 scanning rr_ptr, rr_ptr+1, ... NUM_IN-1, 0, ... cyclically.
REQ-017 Arbitration SHALL be enabled in IDLE, and in SEND when out_ready=1 (flit accepted this cycle).
REQ-018 When enabled and any req set: pop[g]=1 combinationally in that cycle; at the edge out_data<=head slice g, grant_id<=g, rr_ptr<=(g+1) mod NUM_IN, state<=SEND.
REQ-019 When enabled and no req set: pop=0; at the edge state<=IDLE, out_valid<=0, out_data and grant_id hold.
REQ-020 In SEND with out_ready=0: pop=0; out_data, grant_id, out_valid SHALL remain stable.
REQ-021 Latency: req first visible in IDLE cycle N -> pop in cycle N -> out_valid=1 in cycle N+1.
REQ-022 Back-to-back: sustained requests with out_ready=1 SHALL yield one flit per cycle, rotating among requesters.
REQ-023 out_ready while out_valid=0 SHALL be ignored.
REQ-024 Requests with target != PORT_ID SHALL never be popped, regardless of position.
REQ-025 rr_ptr SHALL wrap from NUM_IN-1 to 0; arithmetic in 3 bits, NUM_IN <= 8.

Reset
REQ-026 rst low SHALL immediately force: state IDLE, out_valid 0, out_data 0, grant_id 0, rr_ptr 0, stall counter 0, drop 0, pop all 0 (pop gated by rst).
REQ-027 Reset mid-SEND SHALL discard the held flit without pop or drop; first grant after release starts from input 0.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN defined: 8-bit stall counter increments each SEND cycle with out_ready=0, clears on acceptance or in IDLE; when counter == TIMEOUT-1 and out_ready=0, at the edge out_valid<=0, state<=IDLE, counter<=0, drop=1 for the following cycle; no arbitration that cycle.
REQ-029 Macro ARB_TIMEOUT_EN undefined: no counter; SEND holds indefinitely; drop tied to 0.

Verification
REQ-030 Reset, head_valid=5'b00001, head0 target=0, payload 16'hA5A5, out_ready=1 -> pop=5'b00001 same cycle, next cycle out_valid=1, out_data[22:7]=16'hA5A5, grant_id=0.
REQ-031 All five inputs requesting target 0, out_ready=1, 10 cycles -> grant_id sequence 0,1,2,3,4,0,1,2,3,4, one pop per cycle.
REQ-032 Input 2 head target=3'd1, inputs 1 and 3 target 0 -> pop never asserts bit 2; grants alternate 1,3.
REQ-033 SEND, out_ready=0 for 20 cycles -> out_data/grant_id stable, pop=0; out_ready=1 -> next grant issued same cycle.
REQ-034 ARB_TIMEOUT_EN, TIMEOUT=64, out_ready held 0 -> out_valid falls after 64 stall cycles, drop pulses exactly once; without macro out_valid stays 1.
REQ-035 rst asserted during SEND -> out_valid=0 and pop=0 immediately; after release with requests on 0 and 4, first grant_id=0.

Source files
------------

// File: rtl/router_output_arbiter.sv
// Round-robin output-port arbiter: pops one input-buffer head addressed to PORT_ID and registers it onto the link.
// Latency: pop is asserted in the request cycle and the flit is valid on out_data the next cycle; one flit/cycle sustained.
// Backpressure: out_ready=0 holds the flit and stalls arbitration; with ARB_TIMEOUT_EN defined a flit stalled TIMEOUT cycles is dropped.
module router_output_arbiter #(
  parameter int         NUM_IN  = 5,
  parameter logic [2:0] PORT_ID = 3'd0,
  parameter int         TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_IN*23-1:0] head,
  input  logic [NUM_IN-1:0]    head_valid,
  output logic [NUM_IN-1:0]    pop,
  output logic [22:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           grant_id,
  output logic                 drop
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [2:0]        rr_ptr;
  logic [22:0]       head_arr [NUM_IN];
  logic [NUM_IN-1:0] req;
  logic              any_req;
  logic [2:0]        win_idx;
  logic [3:0]        scan_sum;
  logic              arb_en;
  logic              grant_en;
  logic              stall_expired;

  // Unpack the flattened heads and qualify each one by its target field.
  for (genvar i = 0; i < NUM_IN; i++) begin : g_req
    assign head_arr[i] = head[23*i +: 23];
    assign req[i]      = head_valid[i] && (head_arr[i][2:0] == PORT_ID);
  end

  // A new flit may be taken when the output register is empty or being drained this cycle.
  assign arb_en    = (state == IDLE) || out_ready;
  assign grant_en  = arb_en && any_req;
  assign out_valid = (state == SEND);

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_IN.
  always_comb begin
    any_req  = 1'b0;
    win_idx  = '0;
    scan_sum = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      scan_sum = {1'b0, rr_ptr} + 4'(k);
      if (scan_sum >= 4'(NUM_IN)) scan_sum = scan_sum - 4'(NUM_IN);
      if (!any_req && req[scan_sum[2:0]]) begin
        any_req = 1'b1;
        win_idx = scan_sum[2:0];
      end
    end
  end

  // Pop the winner in the grant cycle; held low while reset is asserted.
  always_comb begin
    pop = '0;
    if (rst && grant_en) pop[win_idx] = 1'b1;
  end

  // Next state: grant -> SEND, nothing to send or stall expired -> IDLE, otherwise hold.
  always_comb begin
    state_nxt = state;
    if (grant_en) state_nxt = SEND;
    else if (arb_en || stall_expired) state_nxt = IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Output flit, source index and round-robin pointer update on every grant; they hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
    end else if (grant_en) begin
      out_data <= head_arr[win_idx];
      grant_id <= win_idx;
      rr_ptr   <= (win_idx == 3'(NUM_IN - 1)) ? 3'd0 : win_idx + 3'd1;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] STALL_LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] stall_cnt;
  logic       drop_q;

  assign stall_expired = (state == SEND) && !out_ready && (stall_cnt == STALL_LIMIT);
  assign drop          = drop_q;

  // Count consecutive refused cycles; on expiry discard the flit and pulse drop for one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      drop_q    <= 1'b0;
    end else begin
      drop_q <= 1'b0;
      if (stall_expired) begin
        stall_cnt <= '0;
        drop_q    <= 1'b1;
      end else if ((state == SEND) && !out_ready) begin
        stall_cnt <= stall_cnt + 8'd1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end
`else
  // Without the stall timer a held flit waits forever and nothing is dropped;
  // the constant-false comparison only keeps TIMEOUT referenced in this build.
  assign stall_expired = 1'b0;
  assign drop          = (TIMEOUT < 0);
`endif

endmodule

// File: tb/tb_router_output_arbiter.sv
// Bench for router_output_arbiter: directed scenarios plus randomized traffic vs. a reference model.
// Inputs are driven on the falling edge; outputs are sampled at the falling edge or 1ns after driving.
// Optional timeout behaviour is checked according to ARB_TIMEOUT_EN.
module tb_router_output_arbiter;

  localparam int         N   = 5;
  localparam logic [2:0] PID = 3'd0;
  localparam int         TMO = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*23-1:0] head = '0;
  logic [N-1:0]   head_valid = '0;
  logic [N-1:0]   pop;
  logic [22:0]    out_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2:0]     grant_id;
  logic           drop;

  int n_tests = 0;
  int n_fail  = 0;

  router_output_arbiter #(.NUM_IN(N), .PORT_ID(PID), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .head(head), .head_valid(head_valid), .pop(pop),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .grant_id(grant_id), .drop(drop)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_ptr;
  bit          m_valid;
  logic [22:0] m_data;
  logic [2:0]  m_gid;
  bit          m_drop;
  int          m_stall;

  task automatic set_head(input int i, input logic [15:0] pl, input logic [3:0] ad, input logic [2:0] tg);
    head[23*i +: 23] = {pl, ad, tg};
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_data = '0; m_gid = '0; m_drop = 0; m_stall = 0;
  endtask

  // First requesting input at or after m_ptr, cyclically; -1 if none.
  function automatic int pick_winner();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (head_valid[i] && head[23*i +: 3] == PID) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_pop();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = pick_winner();
    if ((!m_valid || out_ready) && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_edge();
    int g;
    g = pick_winner();
    m_drop = 0;
    if (!m_valid || out_ready) begin
      m_stall = 0;
      if (g >= 0) begin
        m_valid = 1; m_data = head[23*g +: 23]; m_gid = 3'(g); m_ptr = (g + 1) % N;
      end else begin
        m_valid = 0;
      end
    end else begin
`ifdef ARB_TIMEOUT_EN
      if (m_stall == TMO - 1) begin
        m_valid = 0; m_stall = 0; m_drop = 1;
      end else begin
        m_stall++;
      end
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; head_valid = '0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) set_head(i, 16'h1111, 4'h0, PID);
    head_valid = '1; out_ready = 1'b1;
    rst = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_tests++; if (pop !== '0) begin n_fail++; $display("FAIL reset_pop got %b want 0", pop); end
    n_tests++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_data got %h want 0", out_data); end
    n_tests++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_gid got %0d want 0", grant_id); end
    n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop got %b want 0", drop); end
    @(posedge clk); #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hold_valid got %b want 0", out_valid); end
    @(negedge clk);
    rst = 1'b1; head_valid = '0; out_ready = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    set_head(0, 16'hA5A5, 4'h3, 3'd0);
    head_valid = 5'b00001; out_ready = 1'b1;
    #1;
    n_tests++; if (pop !== 5'b00001) begin n_fail++; $display("FAIL single_pop got %b want 00001", pop); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_tests++; if (out_data[22:7] !== 16'hA5A5) begin n_fail++; $display("FAIL single_payload got %h want a5a5", out_data[22:7]); end
    n_tests++; if (grant_id !== 3'd0) begin n_fail++; $display("FAIL single_gid got %0d want 0", grant_id); end
    head_valid = '0;
  endtask

  task automatic test_rotation();
    logic [22:0]  exp_d [N];
    logic [N-1:0] e;
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_head(i, 16'($urandom), 4'($urandom), 3'd0);
      exp_d[i] = head[23*i +: 23];
    end
    head_valid = '1; out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      e = '0; e[k % N] = 1'b1;
      n_tests++; if (pop !== e) begin n_fail++; $display("FAIL rot_pop[%0d] got %b want %b", k, pop, e); end
      @(negedge clk);
      n_tests++; if (grant_id !== 3'(k % N)) begin n_fail++; $display("FAIL rot_gid[%0d] got %0d want %0d", k, grant_id, k % N); end
      n_tests++; if (out_data !== exp_d[k % N]) begin n_fail++; $display("FAIL rot_data[%0d] got %h want %h", k, out_data, exp_d[k % N]); end
    end
    head_valid = '0;
  endtask

  task automatic test_filter();
    logic [N-1:0] e;
    logic [2:0]   eg;
    do_reset();
    set_head(1, 16'h0101, 4'h1, 3'd0);
    set_head(2, 16'h0202, 4'h2, 3'd1);
    set_head(3, 16'h0303, 4'h3, 3'd0);
    head_valid = 5'b01110; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      e  = (k % 2 == 0) ? 5'b00010 : 5'b01000;
      eg = (k % 2 == 0) ? 3'd1 : 3'd3;
      n_tests++; if (pop !== e) begin n_fail++; $display("FAIL filt_pop[%0d] got %b want %b", k, pop, e); end
      @(negedge clk);
      n_tests++; if (grant_id !== eg) begin n_fail++; $display("FAIL filt_gid[%0d] got %0d want %0d", k, grant_id, eg); end
    end
    head_valid = '0;
  endtask

  task automatic test_stall();
    logic [22:0] exp_d;
    do_reset();
    set_head(0, 16'hBEEF, 4'h1, 3'd0);
    set_head(1, 16'hCAFE, 4'h2, 3'd0);
    exp_d = {16'hBEEF, 4'h1, 3'd0};
    head_valid = 5'b00011; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      set_head(0, 16'($urandom), 4'($urandom), 3'd0);
      #1;
      n_tests++; if (pop !== '0) begin n_fail++; $display("FAIL stall_pop[%0d] got %b want 0", c, pop); end
      @(negedge clk);
      n_tests++; if (out_data !== exp_d || grant_id !== 3'd0 || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d] got data %h gid %0d v %b want %h 0 1", c, out_data, grant_id, out_valid, exp_d);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++; if (pop !== 5'b00010) begin n_fail++; $display("FAIL stall_release_pop got %b want 00010", pop); end
    @(negedge clk);
    n_tests++; if (grant_id !== 3'd1) begin n_fail++; $display("FAIL stall_release_gid got %0d want 1", grant_id); end
    head_valid = '0;
  endtask

  task automatic test_timeout();
    int nv, nd;
    do_reset();
    set_head(2, 16'h5A5A, 4'h2, 3'd0);
    head_valid = 5'b00100; out_ready = 1'b0;
    #1;
    n_tests++; if (pop !== 5'b00100) begin n_fail++; $display("FAIL tmo_idle_pop got %b want 00100", pop); end
    @(negedge clk);
    head_valid = '0;
    nv = 0; nd = 0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid === 1'b1) nv++;
      if (drop === 1'b1) nd++;
      @(negedge clk);
    end
`ifdef ARB_TIMEOUT_EN
    n_tests++; if (nv != TMO) begin n_fail++; $display("FAIL tmo_valid_cycles got %0d want %0d", nv, TMO); end
    n_tests++; if (nd != 1) begin n_fail++; $display("FAIL tmo_drop_count got %0d want 1", nd); end
`else
    n_tests++; if (nv != 100) begin n_fail++; $display("FAIL tmo_valid_cycles got %0d want 100", nv); end
    n_tests++; if (nd != 0) begin n_fail++; $display("FAIL tmo_drop_count got %0d want 0", nd); end
`endif
  endtask

  task automatic test_reset_mid_send();
    do_reset();
    set_head(2, 16'h2222, 4'h2, 3'd0);
    head_valid = 5'b00100; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    set_head(0, 16'h0000, 4'h0, 3'd0);
    set_head(4, 16'h4444, 4'h4, 3'd0);
    head_valid = 5'b10001;
    #2;
    rst = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    n_tests++; if (pop !== '0) begin n_fail++; $display("FAIL midrst_pop got %b want 0", pop); end
    n_tests++; if (drop !== 1'b0) begin n_fail++; $display("FAIL midrst_drop got %b want 0", drop); end
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    #1;
    n_tests++; if (pop !== 5'b00001) begin n_fail++; $display("FAIL midrst_pop_after got %b want 00001", pop); end
    @(negedge clk);
    n_tests++; if (grant_id !== 3'd0 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_gid got %0d v %b want 0 1", grant_id, out_valid);
    end
    head_valid = '0;
  endtask

  task automatic test_random();
    logic [N-1:0] ep;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) set_head(i, 16'($urandom), 4'($urandom), 3'($urandom_range(0, 1)));
      head_valid = N'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      #1;
      ep = exp_pop();
      n_tests++; if (pop !== ep) begin n_fail++; $display("FAIL rnd_pop[%0d] got %b want %b", c, pop, ep); end
      model_edge();
      @(negedge clk);
      n_tests++; if (out_valid !== m_valid || out_data !== m_data || grant_id !== m_gid || drop !== m_drop) begin
        n_fail++;
        $display("FAIL rnd_out[%0d] got v%b d%h g%0d dr%b want v%b d%h g%0d dr%b", c,
                 out_valid, out_data, grant_id, drop, m_valid, m_data, m_gid, m_drop);
      end
    end
    head_valid = '0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_filter();
    test_stall();
    test_timeout();
    test_reset_mid_send();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
